// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding plus the BIST vector record and state encoding.
// Imported by the ALU, the control unit and the self-test sequencer.
package alu_pkg;

    localparam logic [3:0] ALU_NOP   = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_SHL_U = 4'b0011;
    localparam logic [3:0] ALU_SHR_U = 4'b0100;
    localparam logic [3:0] ALU_SHL_S = 4'b0101;
    localparam logic [3:0] ALU_SHR_S = 4'b0110;
    localparam logic [3:0] ALU_LT    = 4'b0111;
    localparam logic [3:0] ALU_EQ    = 4'b1000;
    localparam logic [3:0] ALU_NEQ   = 4'b1001;
    localparam logic [3:0] ALU_AND   = 4'b1010;
    localparam logic [3:0] ALU_OR    = 4'b1011;
    localparam logic [3:0] ALU_XOR   = 4'b1100;
    localparam logic [3:0] ALU_NOR   = 4'b1101;

    localparam int BIST_NUM_VECTORS = 13;

    typedef enum logic [1:0] {
        BIST_IDLE = 2'd0,
        BIST_RUN  = 2'd1,
        BIST_DONE = 2'd2
    } bist_state_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        logic        exp_zero;
    } bist_vec_t;

    // Golden zero flag is derived from the golden result so the two can never disagree.
    function automatic bist_vec_t bist_vec(input logic [3:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] r);
        return '{op, a, b, r, (r == 32'd0)};
    endfunction

endpackage

// File: rtl/alu_bist_rom.sv
// Fixed self-test vector table: index -> opcode, operands and golden outputs.
// Purely combinational; unused indices return an all-zero no-op entry.
module alu_bist_rom
    import alu_pkg::*;
(
    input  logic [3:0] idx_i,
    output bist_vec_t  vec_o
);

    always_comb begin
        vec_o = '0;
        case (idx_i)
            4'd0:  vec_o = bist_vec(ALU_ADD,   32'h0000_0005, 32'd3, 32'h0000_0008);
            4'd1:  vec_o = bist_vec(ALU_SUB,   32'h0000_000A, 32'd3, 32'h0000_0007);
            4'd2:  vec_o = bist_vec(ALU_SHL_U, 32'h0000_0001, 32'd2, 32'h0000_0004);
            4'd3:  vec_o = bist_vec(ALU_SHR_U, 32'h0000_0008, 32'd2, 32'h0000_0002);
            4'd4:  vec_o = bist_vec(ALU_SHL_S, 32'hFFFF_FFF0, 32'd2, 32'hFFFF_FFC0);
            4'd5:  vec_o = bist_vec(ALU_SHR_S, 32'hFFFF_FFF0, 32'd2, 32'hFFFF_FFFC);
            4'd6:  vec_o = bist_vec(ALU_LT,    32'h0000_0005, 32'd3, 32'h0000_0000);
            4'd7:  vec_o = bist_vec(ALU_EQ,    32'h0000_0005, 32'd5, 32'h0000_0001);
            4'd8:  vec_o = bist_vec(ALU_NEQ,   32'h0000_0005, 32'd3, 32'h0000_0001);
            4'd9:  vec_o = bist_vec(ALU_AND,   32'h0000_000F, 32'd3, 32'h0000_0003);
            4'd10: vec_o = bist_vec(ALU_OR,    32'h0000_000F, 32'd3, 32'h0000_000F);
            4'd11: vec_o = bist_vec(ALU_XOR,   32'h0000_000F, 32'd3, 32'h0000_000C);
            4'd12: vec_o = bist_vec(ALU_NOR,   32'h0000_000F, 32'd3, 32'hFFFF_FFF0);
            default: vec_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test sequencer: walks the vector ROM, checks result/zero_flag, keeps statistics.
// Each vector is held SETTLE_CYCLES+1 cycles; start is ignored while a run is in progress.
module alu_bist
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter bit STOP_ON_FAIL  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_count,
    output logic [3:0]  first_fail_op
);

    localparam logic [2:0] SETTLE_MAX = 3'(SETTLE_CYCLES);
    localparam logic [3:0] LAST_IDX   = 4'(BIST_NUM_VECTORS - 1);

    bist_state_e state_q;
    logic [3:0]  idx_q;
    logic [2:0]  settle_q;
    logic [3:0]  alu_op_q;
    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;
    logic [31:0] exp_result_q;
    logic        exp_zero_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [3:0]  fail_count_q;
    logic [3:0]  first_fail_op_q;

    // The ROM is only ever addressed with the vector to load next; golden values ride along in registers.
    logic [3:0]  idx_d;
    bist_vec_t   vec_d;
    logic        mismatch;
    logic        last_vec;

    assign idx_d    = (state_q == BIST_RUN) ? idx_q + 4'd1 : 4'd0;
    assign mismatch = (alu_result != exp_result_q) || (alu_zero != exp_zero_q);
    assign last_vec = (idx_q == LAST_IDX);

    alu_bist_rom u_rom (
        .idx_i (idx_d),
        .vec_o (vec_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= BIST_IDLE;
            idx_q           <= 4'd0;
            settle_q        <= 3'd0;
            alu_op_q        <= ALU_NOP;
            alu_a_q         <= 32'd0;
            alu_b_q         <= 32'd0;
            exp_result_q    <= 32'd0;
            exp_zero_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            fail_count_q    <= 4'd0;
            first_fail_op_q <= ALU_NOP;
        end else begin
            case (state_q)
                BIST_IDLE, BIST_DONE: begin
                    if (start) begin
                        state_q         <= BIST_RUN;
                        idx_q           <= 4'd0;
                        settle_q        <= 3'd0;
                        alu_op_q        <= vec_d.op;
                        alu_a_q         <= vec_d.a;
                        alu_b_q         <= vec_d.b;
                        exp_result_q    <= vec_d.exp_result;
                        exp_zero_q      <= vec_d.exp_zero;
                        busy_q          <= 1'b1;
                        done_q          <= 1'b0;
                        pass_q          <= 1'b0;
                        fail_count_q    <= 4'd0;
                        first_fail_op_q <= ALU_NOP;
                    end
                end
                BIST_RUN: begin
                    if (settle_q < SETTLE_MAX) begin
                        settle_q <= settle_q + 3'd1;
                    end else begin
                        if (mismatch) begin
                            if (fail_count_q != 4'hF) begin
                                fail_count_q <= fail_count_q + 4'd1;
                            end
                            if (fail_count_q == 4'd0) begin
                                first_fail_op_q <= alu_op_q;
                            end
                        end
                        if (last_vec || (STOP_ON_FAIL && mismatch)) begin
                            state_q  <= BIST_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            pass_q   <= last_vec && !mismatch && (fail_count_q == 4'd0);
                            alu_op_q <= ALU_NOP;
                            alu_a_q  <= 32'd0;
                            alu_b_q  <= 32'd0;
                        end else begin
                            idx_q        <= idx_d;
                            settle_q     <= 3'd0;
                            alu_op_q     <= vec_d.op;
                            alu_a_q      <= vec_d.a;
                            alu_b_q      <= vec_d.b;
                            exp_result_q <= vec_d.exp_result;
                            exp_zero_q   <= vec_d.exp_zero;
                        end
                    end
                end
                default: state_q <= BIST_IDLE;
            endcase
        end
    end

    assign alu_op        = alu_op_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail_count    = fail_count_q;
    assign first_fail_op = first_fail_op_q;

endmodule
